// File: rtl/param_program_sequencer.sv
// ---------------------------------------------------------------------------
// param_program_sequencer
//
// Program-counter sequencer with jump, conditional jump, call/return through a
// small return-address stack, and an optional instruction counter.
//
// Parameters:
//   PC_W        width of pc / pm_addr / from_PS (4..16)
//   JA_W        width of jmp_addr (1..PC_W); target = {jmp_addr, zeros}
//   STACK_DEPTH number of return-address entries (1..16)
//
// Ports:
//   clk            sole clock, rising edge
//   async_reset_n  asynchronous active-low reset
//   sync_reset     synchronous restart (pm_addr forced to 0)
//   jmp            unconditional jump to target
//   jmp_nz         conditional jump, taken when dont_jmp is 0
//   dont_jmp       zero-flag qualifier for jmp_nz
//   call           jump to target and push pc+1
//   ret            pop return address and jump to it
//   jmp_addr       target upper bits / counter add operand
//   NOPC8          counter increment strobe
//   load_instr     counter add strobe
//   pm_addr        combinational next program-memory address
//   pc             registered current address
//   from_PS        counter value (counter build) or pc (default build)
//   stack_full     registered: occupancy == STACK_DEPTH
//   stack_empty    registered: occupancy == 0
//   stack_err      sticky overflow/underflow flag
//
// Build option:
//   PROGRAM_SEQUENCER_COUNTER_EN  when defined, builds the PC_W-bit
//   instruction counter and routes it to from_PS.
// ---------------------------------------------------------------------------
module param_program_sequencer #(
    parameter int PC_W        = 8,
    parameter int JA_W        = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            async_reset_n,
    input  logic            sync_reset,
    input  logic            jmp,
    input  logic            jmp_nz,
    input  logic            dont_jmp,
    input  logic            call,
    input  logic            ret,
    input  logic [JA_W-1:0] jmp_addr,
    input  logic            NOPC8,
    input  logic            load_instr,
    output logic [PC_W-1:0] pm_addr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] from_PS,
    output logic            stack_full,
    output logic            stack_empty,
    output logic            stack_err
);

    localparam int OCC_W = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  pc_inc;
    logic             take_jmp;
    logic             masked;
    logic             take_call;
    logic             take_ret;
    logic             call_err;
    logic             ret_err;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;

    // Entry 0 is always the top of stack; push shifts down, pop shifts up,
    // so no pointer arithmetic is needed to address the top.
    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];

    assign target = PC_W'(jmp_addr) << (PC_W - JA_W);
    assign pc_inc = pc + PC_W'(1);

    // A call or ret only acts when no higher-priority source claims the
    // cycle; call always shadows ret, even when the call itself is refused.
    always_comb begin
        take_jmp  = jmp | (jmp_nz & ~dont_jmp);
        masked    = sync_reset | take_jmp;
        take_call = ~masked & call & ~stack_full;
        call_err  = ~masked & call & stack_full;
        take_ret  = ~masked & ~call & ret & ~stack_empty;
        ret_err   = ~masked & ~call & ret & stack_empty;
    end

    always_comb begin
        pm_addr = pc_inc;
        if (sync_reset)
            pm_addr = '0;
        else if (take_jmp || take_call)
            pm_addr = target;
        else if (take_ret)
            pm_addr = stack_mem[0];
    end

    always_comb begin
        occ_next = occ;
        if (take_call)
            occ_next = occ + OCC_W'(1);
        else if (take_ret)
            occ_next = occ - OCC_W'(1);
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            pc          <= '0;
            occ         <= '0;
            stack_full  <= 1'b0;
            stack_empty <= 1'b1;
            stack_err   <= 1'b0;
        end else begin
            pc <= pm_addr;
            if (sync_reset) begin
                occ         <= '0;
                stack_full  <= 1'b0;
                stack_empty <= 1'b1;
                stack_err   <= 1'b0;
            end else begin
                occ         <= occ_next;
                stack_full  <= (occ_next == OCC_W'(STACK_DEPTH));
                stack_empty <= (occ_next == '0);
                if (call_err || ret_err)
                    stack_err <= 1'b1;
            end
        end
    end

    // Return-address storage carries no reset: entries beyond the occupancy
    // are never selected because pops are refused while empty.
    always_ff @(posedge clk) begin
        if (take_call) begin
            stack_mem[0] <= pc_inc;
            for (int i = 1; i < STACK_DEPTH; i++)
                stack_mem[i] <= stack_mem[i-1];
        end else if (take_ret) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++)
                stack_mem[i] <= stack_mem[i+1];
        end
    end

`ifdef PROGRAM_SEQUENCER_COUNTER_EN
    logic [PC_W-1:0] counter;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n)
            counter <= '0;
        else if (sync_reset)
            counter <= '0;
        else if (NOPC8)
            counter <= counter + PC_W'(1);
        else if (load_instr)
            counter <= counter + PC_W'(jmp_addr);
    end

    assign from_PS = counter;
`else
    // Counter strobes have no function in this build.
    logic unused_counter_inputs;
    assign unused_counter_inputs = NOPC8 ^ load_instr;

    assign from_PS = pc;
`endif

endmodule
